regfile_pipe: RTL

- Parametrised, clocked general-purpose register file for the single-cycle datapath.
- Provides two combinational read ports, one synchronous write port, register 0 hardwired to zero, and the ALU operand-B select with sign- or zero-extended immediate.
- Adds a handshaked register-dump engine that streams every register out for bench/debug capture, replacing file-based register dumps.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_dump_ctrl.sv | 76 +++++++
 rtl/regfile_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared widths, dump FSM state type and immediate extension helper
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_IMM_W  = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } dump_state_e;

    // Default-width immediate extension, shared with the branch/offset datapath
    function automatic logic [RF_DATA_W-1:0] sext_imm(input logic [RF_IMM_W-1:0] imm,
                                                      input logic                sext);
        return {{(RF_DATA_W-RF_IMM_W){sext & imm[RF_IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/rf_dump_ctrl.sv
// rtl/rf_dump_ctrl.sv - register dump engine: streams every register as valid/ready beats
// Beat data is captured from the array at the load edge, so later writes never alter a held beat.
module rf_dump_ctrl
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dump_req,
    input  logic              dump_ready,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic [ADDR_W-1:0] rd_idx,
    input  logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        // Look-ahead read of the next register so a handshake reloads with no bubble
        rd_idx  = idx_q + ADDR_W'(1);
        case (state_q)
            IDLE: begin
                if (dump_req) begin
                    state_d = STREAM;
                    idx_d   = '0;
                    data_d  = '0;
                end
            end
            STREAM: begin
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        data_d  = '0;
                    end else begin
                        idx_d  = rd_idx;
                        data_d = rd_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dump_busy  = (state_q == STREAM);
    assign dump_valid = (state_q == STREAM);
    assign dump_idx   = idx_q;
    assign dump_data  = data_q;
    assign dump_last  = dump_valid && (idx_q == LAST_IDX);

endmodule

// File: rtl/regfile_pipe.sv
// rtl/regfile_pipe.sv - 2R/1W register file with r0 = 0, operand-B select and dump engine
// Define RF_BYPASS_EN for same-cycle write-through forwarding onto the read ports.
module regfile_pipe
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int IMM_W  = RF_IMM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] op_b,
    input  logic [IMM_W-1:0]  imm,
    input  logic              imm_sext,
    input  logic              alu_src,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              dump_req,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] rs_arr, rt_arr, imm_ext, dump_rd_data;
    logic [ADDR_W-1:0] dump_rd_idx;
    logic              wr_en;

    assign wr_en = we && (waddr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rs_arr = (rs_addr == '0) ? '0 : regs_q[rs_addr];
    assign rt_arr = (rt_addr == '0) ? '0 : regs_q[rt_addr];

`ifdef RF_BYPASS_EN
    assign rs_data = (wr_en && (waddr == rs_addr)) ? wdata : rs_arr;
    assign rt_data = (wr_en && (waddr == rt_addr)) ? wdata : rt_arr;
`else
    assign rs_data = rs_arr;
    assign rt_data = rt_arr;
`endif

    generate
        if (DATA_W > IMM_W) begin : g_ext
            assign imm_ext = {{(DATA_W-IMM_W){imm_sext & imm[IMM_W-1]}}, imm};
        end else begin : g_noext
            assign imm_ext = imm;
        end
    endgenerate

    assign op_b = alu_src ? imm_ext : rt_data;

    // Dump port reads the raw array: forwarding never leaks into a snapshot
    assign dump_rd_data = regs_q[dump_rd_idx];

    rf_dump_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_dump_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .dump_req  (dump_req),
        .dump_ready(dump_ready),
        .dump_busy (dump_busy),
        .dump_valid(dump_valid),
        .dump_idx  (dump_idx),
        .dump_data (dump_data),
        .dump_last (dump_last),
        .rd_idx    (dump_rd_idx),
        .rd_data   (dump_rd_data)
    );

endmodule
